// File: rtl/led_pkg.sv
// Shared definitions for the LED blink array: channel mode encoding.
// The mode encoding is also used by software register maps, so values are fixed.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode, period, high time and a counter, and produces
// a registered lit flag plus a one-cycle wrap pulse.
import led_pkg::*;

module led_channel #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  led_mode_e        wr_mode,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    input  logic             sync,
    output logic             lit,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    led_mode_e        mode_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lit_r;
    logic             wrap_r;

    led_mode_e        mode_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             lit_next_s;
    logic             wrap_next_s;
    logic             period_end_s;
    logic             high_end_s;

    // Next-state and next-output decode from the current channel state.
    always_comb begin
        mode_next_s  = mode_r;
        cnt_next_s   = CNT_ZERO;
        lit_next_s   = 1'b0;
        wrap_next_s  = 1'b0;
        // Only meaningful when period/high are non-zero; the cases below gate on that.
        period_end_s = (cnt_r == (period_r - CNT_ONE));
        high_end_s   = (cnt_r == (high_r - CNT_ONE));
        case (mode_r)
            MODE_OFF: begin
                lit_next_s = 1'b0;
            end
            MODE_ON: begin
                lit_next_s = 1'b1;
            end
            MODE_BLINK: begin
                if (period_r == CNT_ZERO) begin
                    lit_next_s = 1'b0;
                end else begin
                    lit_next_s  = (cnt_r < high_r);
                    wrap_next_s = period_end_s;
                    // sync restarts the phase; otherwise count 0..period-1.
                    cnt_next_s  = (sync || period_end_s) ? CNT_ZERO : (cnt_r + CNT_ONE);
                end
            end
            MODE_ONESHOT: begin
                if (high_r == CNT_ZERO) begin
                    mode_next_s = MODE_OFF;
                end else begin
                    lit_next_s  = (cnt_r < high_r);
                    wrap_next_s = high_end_s;
                    if (high_end_s) begin
                        mode_next_s = MODE_OFF;
                        cnt_next_s  = CNT_ZERO;
                    end else begin
                        cnt_next_s  = cnt_r + CNT_ONE;
                    end
                end
            end
            default: begin
                mode_next_s = MODE_OFF;
            end
        endcase
    end

    // Channel state and registered outputs; reset beats a write, a write beats sync/counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r   <= MODE_OFF;
            period_r <= CNT_ZERO;
            high_r   <= CNT_ZERO;
            cnt_r    <= CNT_ZERO;
            lit_r    <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (wr_en) begin
            mode_r   <= wr_mode;
            period_r <= wr_period;
            high_r   <= wr_high;
            cnt_r    <= CNT_ZERO;
            lit_r    <= lit_next_s;
            // The interrupted period or one-shot never reports completion.
            wrap_r   <= 1'b0;
        end else begin
            mode_r   <= mode_next_s;
            cnt_r    <= cnt_next_s;
            lit_r    <= lit_next_s;
            wrap_r   <= wrap_next_s;
        end
    end

    assign lit  = lit_r;
    assign wrap = wrap_r;

endmodule

// File: rtl/led_blink_array.sv
// Array of independent LED channels with a single configuration write port,
// a global phase-align input and selectable output polarity.
import led_pkg::*;

module led_blink_array #(
    parameter int NUM_CH     = 6,
    parameter int CNT_W      = 26,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                cfg_mode,
    input  logic [CNT_W-1:0]                          cfg_period,
    input  logic [CNT_W-1:0]                          cfg_high,
    input  logic                                      sync,
    output logic [NUM_CH-1:0]                         o_leds,
    output logic [NUM_CH-1:0]                         o_wrap
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              ready_r;
    logic              wr_fire_s;
    logic [NUM_CH-1:0] lit_s;
    logic [NUM_CH-1:0] wrap_s;

    // Ready stays low through reset and the first cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    assign cfg_ready = ready_r & ~rst;
    assign wr_fire_s = cfg_valid & cfg_ready;

    // Channels beyond NUM_CH never match, so such writes are silently dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_fire_s && (cfg_ch == CH_W'(i))),
            .wr_mode   (led_mode_e'(cfg_mode)),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .sync      (sync),
            .lit       (lit_s[i]),
            .wrap      (wrap_s[i])
        );
    end

    assign o_leds = ACTIVE_LOW ? ~lit_s : lit_s;
    assign o_wrap = wrap_s;

endmodule

// File: tb/tb_led_blink_array.sv
// Scoreboard bench for led_blink_array: stimulus pushes per-cycle expectations,
// a monitor on the falling edge pops and compares them.
import led_pkg::*;

module tb_led_blink_array;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic              sync;
    logic [NUM_CH-1:0] o_leds;
    logic [NUM_CH-1:0] o_wrap;

    led_blink_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_high(cfg_high), .sync(sync), .o_leds(o_leds), .o_wrap(o_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] lm;
        logic [NUM_CH-1:0] lv;
        logic [NUM_CH-1:0] wm;
        logic [NUM_CH-1:0] wv;
        bit                cr;
        bit                rv;
        int                tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic string tag_name(input int t);
        case (t)
            0: return "reset";
            1: return "blink_p10_h3";
            2: return "blink_p0";
            3: return "blink_h_ge_p";
            4: return "on_off";
            5: return "oneshot_h5";
            6: return "oneshot_h0";
            7: return "sync_ch0";
            8: return "sync_ch3";
            9: return "invalid_ch";
            10: return "rst_midop";
            11: return "ready";
            default: return "other";
        endcase
    endfunction

    function automatic void push(input exp_t e);
        int i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endfunction

    function automatic void expect_ch(input int c, input int cy, input bit lit, input bit wr, input int tag);
        exp_t e;
        e.cyc = cy; e.lm = '0; e.lv = '0; e.wm = '0; e.wv = '0;
        e.lm[c] = 1'b1; e.lv[c] = !lit;
        e.wm[c] = 1'b1; e.wv[c] = wr;
        e.cr = 1'b0; e.rv = 1'b0; e.tag = tag;
        push(e);
    endfunction

    function automatic void expect_all(input int cy, input logic [NUM_CH-1:0] leds,
                                       input logic [NUM_CH-1:0] wrap, input bit chk,
                                       input bit rdy, input bit chk_ready, input int tag);
        exp_t e;
        e.cyc = cy;
        e.lm = chk ? {NUM_CH{1'b1}} : '0; e.lv = leds;
        e.wm = chk ? {NUM_CH{1'b1}} : '0; e.wv = wrap;
        e.cr = chk_ready; e.rv = rdy; e.tag = tag;
        push(e);
    endfunction

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++; failures++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", tag_name(e.tag), e.cyc, cyc);
            end else begin
                if (e.lm != '0) begin
                    checks++;
                    if ((o_leds & e.lm) !== (e.lv & e.lm)) begin
                        failures++;
                        $display("FAIL %s o_leds cyc=%0d got=%b exp=%b mask=%b",
                                 tag_name(e.tag), cyc, o_leds, e.lv, e.lm);
                    end
                end
                if (e.wm != '0) begin
                    checks++;
                    if ((o_wrap & e.wm) !== (e.wv & e.wm)) begin
                        failures++;
                        $display("FAIL %s o_wrap cyc=%0d got=%b exp=%b mask=%b",
                                 tag_name(e.tag), cyc, o_wrap, e.wv, e.wm);
                    end
                end
                if (e.cr) begin
                    checks++;
                    if (cfg_ready !== e.rv) begin
                        failures++;
                        $display("FAIL %s cfg_ready cyc=%0d got=%b exp=%b",
                                 tag_name(e.tag), cyc, cfg_ready, e.rv);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int ch, input logic [1:0] m, input int p, input int h, output int base);
        base       = cyc;
        cfg_valid  = 1'b1;
        cfg_ch     = ch[2:0];
        cfg_mode   = m;
        cfg_period = p[CNT_W-1:0];
        cfg_high   = h[CNT_W-1:0];
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
    endtask

    task automatic check_mode_off(input int tag);
        checks++;
        if (dut.g_ch[2].u_ch.mode_r !== MODE_OFF) begin
            failures++;
            $display("FAIL %s mode got=%0d exp=%0d", tag_name(tag),
                     dut.g_ch[2].u_ch.mode_r, MODE_OFF);
        end
    endtask

    initial begin
        int b, a, s, r, k;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_mode = 2'd0;
        cfg_period = '0; cfg_high = '0; sync = 1'b0;

        // Reset: all unlit, no wraps, not ready through the first cycle after reset.
        expect_all(1, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b1, 0);
        expect_all(2, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b1, 0);
        expect_all(3, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b1, 0);
        expect_all(4, 6'h3F, 6'h00, 1'b1, 1'b1, 1'b1, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);

        // ch0 BLINK period 10 high 3.
        do_write(0, 2'd2, 10, 3, b);
        for (int i = 0; i < 25; i++) expect_ch(0, b + 2 + i, (i % 10) < 3, (i % 10) == 9, 1);
        expect_all(b + 3, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 11);
        wait_cyc(25);

        // ch1 BLINK period 0: never lit, never wraps.
        do_write(1, 2'd2, 0, 3, b);
        for (int i = 0; i < 12; i++) expect_ch(1, b + 2 + i, 1'b0, 1'b0, 2);
        wait_cyc(12);
        // ch1 BLINK period 4 high 9: always lit, wraps every 4.
        do_write(1, 2'd2, 4, 9, b);
        for (int i = 0; i < 12; i++) expect_ch(1, b + 2 + i, 1'b1, (i % 4) == 3, 3);
        wait_cyc(12);

        // ch5 ON then OFF.
        do_write(5, 2'd1, 0, 0, b);
        for (int i = 0; i < 5; i++) expect_ch(5, b + 2 + i, 1'b1, 1'b0, 4);
        wait_cyc(5);
        do_write(5, 2'd0, 0, 0, b);
        for (int i = 0; i < 4; i++) expect_ch(5, b + 2 + i, 1'b0, 1'b0, 4);
        wait_cyc(4);

        // ch2 ONESHOT high 5 (period ignored).
        do_write(2, 2'd3, 3, 5, b);
        for (int i = 0; i < 10; i++) expect_ch(2, b + 2 + i, i < 5, i == 4, 5);
        wait_cyc(10);
        check_mode_off(5);
        // ch2 ONESHOT high 0: no lit cycle, no wrap.
        do_write(2, 2'd3, 3, 0, b);
        for (int i = 0; i < 4; i++) expect_ch(2, b + 2 + i, 1'b0, 1'b0, 6);
        wait_cyc(4);
        check_mode_off(6);

        // Sync: ch0 p10 h3 and ch3 p7 h2 restarted mid-period, plus a write to channel 6.
        a = cyc; b = a + 1; s = a + 6;
        do_write(0, 2'd2, 10, 3, a);
        for (int cy = a + 2; cy <= s + 1; cy++) begin
            k = cy - (a + 2);
            expect_ch(0, cy, (k % 10) < 3, (k % 10) == 9, 7);
        end
        for (int cy = b + 2; cy <= s + 1; cy++) begin
            k = cy - (b + 2);
            expect_ch(3, cy, (k % 7) < 2, (k % 7) == 6, 8);
        end
        for (int i = 0; i < 20; i++) begin
            expect_ch(0, s + 2 + i, (i % 10) < 3, (i % 10) == 9, 7);
            expect_ch(3, s + 2 + i, (i % 7) < 2, (i % 7) == 6, 8);
            expect_ch(2, s + 2 + i, 1'b0, 1'b0, 9);
            expect_ch(4, s + 2 + i, 1'b0, 1'b0, 9);
            expect_ch(5, s + 2 + i, 1'b0, 1'b0, 9);
        end
        do_write(3, 2'd2, 7, 2, b);
        wait_cyc(4);
        sync = 1'b1;
        wait_cyc(1);
        sync = 1'b0;
        do_write(6, 2'd2, 2, 1, b);
        wait_cyc(20);

        // Reset mid-operation with a simultaneous write that must be ignored.
        r = cyc;
        expect_all(r, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 10);
        expect_all(r + 1, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b1, 10);
        expect_all(r + 2, 6'h3F, 6'h00, 1'b1, 1'b1, 1'b1, 10);
        for (int i = 3; i < 7; i++) expect_all(r + i, 6'h3F, 6'h00, 1'b1, 1'b1, 1'b0, 10);
        rst = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 3'd4; cfg_mode = 2'd1;
        wait_cyc(1);
        rst = 1'b0; cfg_valid = 1'b0;
        wait_cyc(6);

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && q.size() > 0; i++) wait_cyc(1);
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
